// File: rtl/uart_pkg.sv
// Shared UART receive types and defaults.
// UART_RX_PARITY_EN adds the PARITY state (even parity).
package uart_pkg;

  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_OVERSAMPLE = 16;

  // Expected parity bit equals XOR of the data bits XOR this constant (0 = even).
  localparam logic PARITY_ODD = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer for one asynchronous input; RESET_VAL sets both flops in reset.
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk50,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver, LSB first, advancing only on tick.
// Optional even-parity bit and parity_err output with UART_RX_PARITY_EN.
//
// state  | meaning
// IDLE   | line idle, waiting for a low sample
// START  | counting to mid start bit to reject glitches
// DATA   | sampling DATA_BITS data bits at bit centres
// PARITY | sampling the parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling the stop bit, reporting the frame
// BREAK  | stop bit was low; waiting for the line to return high
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic                 clk50,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  logic rx_s;
  rx_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bit_idx, bit_n;
  logic [DATA_BITS-1:0] shreg, shreg_n, data_n;
  logic dv_n, fe_n;
`ifdef UART_RX_PARITY_EN
  logic par_bit, par_n, pe_n;
`endif

  sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk50 (clk50),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_n;
      shreg      <= shreg_n;
      data       <= data_n;
      data_valid <= dv_n;
      frame_err  <= fe_n;
`ifdef UART_RX_PARITY_EN
      par_bit    <= par_n;
      parity_err <= pe_n;
`endif
    end
  end

  // Pulse outputs default low every cycle, so they stay one clk50 wide at any tick rate.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    shreg_n = shreg;
    data_n  = data;
    dv_n    = 1'b0;
    fe_n    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_n   = par_bit;
    pe_n    = 1'b0;
`endif
    if (tick) begin
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state_n = ST_START;
            cnt_n   = '0;
          end
        end
        ST_START: begin
          if (cnt == MID) begin
            cnt_n   = '0;
            bit_n   = '0;
            state_n = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == LAST) begin
            cnt_n   = '0;
            shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
            bit_n   = bit_idx + 1'b1;
            if (bit_idx == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_n = ST_PARITY;
`else
              state_n = ST_STOP;
`endif
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt == LAST) begin
            cnt_n   = '0;
            par_n   = rx_s;
            state_n = ST_STOP;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (cnt == LAST) begin
            cnt_n = '0;
            if (rx_s) begin
              state_n = ST_IDLE;
`ifdef UART_RX_PARITY_EN
              if (par_bit != ((^shreg) ^ PARITY_ODD)) begin
                pe_n = 1'b1;
              end else begin
                data_n = shreg;
                dv_n   = 1'b1;
              end
`else
              data_n = shreg;
              dv_n   = 1'b1;
`endif
            end else begin
              fe_n    = 1'b1;
              state_n = ST_BREAK;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        ST_BREAK: begin
          if (rx_s) state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames and tick rates.
module tb_uart_rx;

  localparam int DB = 8;
  localparam int OS = 16;

  logic clk50 = 1'b0;
  logic reset = 1'b1;
  logic tick  = 1'b0;
  logic rx    = 1'b1;
  logic [DB-1:0] data;
  logic data_valid, frame_err, busy;
`ifdef UART_RX_PARITY_EN
  logic parity_err;
`endif

  int total = 0;
  int bad   = 0;
  int n_dv = 0, n_fe = 0, exp_dv = 0, exp_fe = 0;
  int tick_gap = 4;
  logic [DB-1:0] exp_data = '0;
  logic [DB-1:0] exp_q[$];

  uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .clk50      (clk50),
    .reset      (reset),
    .tick       (tick),
    .rx         (rx),
    .data       (data),
    .data_valid (data_valid),
    .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .busy       (busy)
  );

  always #10 clk50 = ~clk50;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // tick: one clk50 wide, once every tick_gap cycles
  initial begin
    int c;
    c = 0;
    forever begin
      @(negedge clk50);
      if (c >= tick_gap - 1) begin
        tick = 1'b1;
        c = 0;
      end else begin
        tick = 1'b0;
        c++;
      end
    end
  end

  // Pulse monitor: width, exclusivity and order of received bytes
  initial begin
    logic prev_dv, prev_fe;
    prev_dv = 1'b0;
    prev_fe = 1'b0;
    forever begin
      @(negedge clk50);
      if (!reset) begin
        if (data_valid) begin
          n_dv++;
          check("dv_width", prev_dv, 0);
          check("dv_fe_excl", frame_err, 0);
          if (exp_q.size() == 0) check("dv_unexpected", data_valid, 0);
          else check("dv_data", data, exp_q.pop_front());
        end
        if (frame_err) begin
          n_fe++;
          check("fe_width", prev_fe, 0);
        end
      end
      prev_dv = data_valid;
      prev_fe = frame_err;
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk50); while (tick !== 1'b1);
    end
  endtask

  task automatic send_bit(input logic b, input int n);
    #1 rx = b;
    wait_ticks(n);
  endtask

  // Frame-level model: a good stop bit delivers the byte, a low stop bit is a framing error.
  task automatic send_frame(input logic [DB-1:0] b, input bit stop_ok, input int hold);
    if (stop_ok) exp_q.push_back(b);
    send_bit(1'b0, OS);
    for (int i = 0; i < DB; i++) send_bit(b[i], OS);
    if (stop_ok) begin
      send_bit(1'b1, OS);
      exp_data = b;
      exp_dv++;
    end else begin
      send_bit(1'b0, hold);
      exp_fe++;
    end
  endtask

  initial begin
    #1_900_000;
    bad++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int base_dv, base_fe;
    logic [DB-1:0] b;
    bit ok;
    int gap;

    repeat (3) @(posedge clk50);
    @(negedge clk50);
    check("rst_data", data, 0);
    check("rst_dv", data_valid, 0);
    check("rst_fe", frame_err, 0);
    check("rst_busy", busy, 0);
    @(posedge clk50);
    #1 reset = 1'b0;
    send_bit(1'b1, 4);

    // single good frame
    base_dv = n_dv; base_fe = n_fe;
    send_frame(8'hA5, 1'b1, 0);
    check("a5_data", data, 8'hA5);
    check("a5_dv_cnt", n_dv - base_dv, 1);
    check("a5_fe_cnt", n_fe - base_fe, 0);
    check("a5_busy", busy, 0);

    // start glitch
    base_dv = n_dv;
    send_bit(1'b0, 4);
    check("glitch_busy_hi", busy, 1);
    send_bit(1'b1, 12);
    check("glitch_busy_lo", busy, 0);
    check("glitch_dv_cnt", n_dv - base_dv, 0);
    check("glitch_data", data, 8'hA5);

    // framing error, break, recovery
    base_dv = n_dv; base_fe = n_fe;
    send_frame(8'h3C, 1'b0, 40);
    check("ferr_fe_cnt", n_fe - base_fe, 1);
    check("ferr_dv_cnt", n_dv - base_dv, 0);
    check("ferr_busy", busy, 1);
    check("ferr_data", data, 8'hA5);
    send_bit(1'b1, 4);
    check("brk_busy", busy, 0);
    send_frame(8'h55, 1'b1, 0);
    check("rec_data", data, 8'h55);

    // back-to-back frames
    base_dv = n_dv;
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    check("b2b_dv_cnt", n_dv - base_dv, 2);
    check("b2b_data", data, 8'hFF);

    // reset mid-frame
    base_dv = n_dv;
    send_bit(1'b0, OS);
    send_bit(1'b1, OS);
    send_bit(1'b0, OS);
    send_bit(1'b0, OS);
    @(posedge clk50);
    #1 reset = 1'b1;
    rx = 1'b1;
    exp_data = '0;
    repeat (2) @(negedge clk50);
    check("mrst_data", data, 0);
    check("mrst_dv", data_valid, 0);
    check("mrst_fe", frame_err, 0);
    check("mrst_busy", busy, 0);
    @(posedge clk50);
    #1 reset = 1'b0;
    send_bit(1'b1, OS);
    check("mrst_data_after", data, exp_data);
    send_frame(8'h42, 1'b1, 0);
    check("mrst_dv_cnt", n_dv - base_dv, 1);
    check("mrst_42", data, 8'h42);

    // randomized frames, stop bits and tick rates
    for (int k = 0; k < 24; k++) begin
      b = DB'($urandom_range(0, 255));
      ok = ($urandom_range(0, 4) != 0);
      gap = $urandom_range(0, 2);
      tick_gap = $urandom_range(1, 5);
      send_frame(b, ok, $urandom_range(16, 40));
      if (!ok) begin
        check("rnd_brk_busy", busy, 1);
        send_bit(1'b1, 4);
      end else if (gap > 0) begin
        send_bit(1'b1, gap * OS);
      end
      check("rnd_data", data, exp_data);
      check("rnd_busy", busy, 0);
    end

    repeat (20) @(posedge clk50);
    check("n_valid", n_dv, exp_dv);
    check("n_ferr", n_fe, exp_fe);
    check("q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
